// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types, constants and helpers for the instruction fetch
// stage (fetch_unit, fetch_queue).
//   INSTR_BYTES   : bytes per instruction word.
//   fetch_entry_t : one queued instruction (word and its PC).
//   epoch_tag_t   : epoch bit carried by every outstanding read.
//   branch_target : redirect address from the Execute PC and an
//                   instruction-granular signed offset.
package fetch_pkg;

  localparam int unsigned INSTR_BYTES = 4;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } fetch_entry_t;

  typedef logic epoch_tag_t;

  // Offset is in instructions, so scale to bytes; the add wraps at 2^32.
  function automatic logic [31:0] branch_target(input logic [31:0] ex_pc,
                                                input logic [31:0] delta);
    branch_target = ex_pc + (delta << 2);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: groups the instruction-memory read port and the Decode
// valid/ready handshake of the fetch stage.
//   imem_req/imem_addr      : read strobe and word address (fetch -> imem)
//   imem_rdata/imem_rvalid  : returned word and its strobe (imem -> fetch)
//   instr_valid/instr/instr_pc : instruction offered to Decode
//   instr_ready             : Decode accepts the offered instruction
// Modports: master = fetch stage side, slave = memory/Decode side.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_rvalid;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_rdata, imem_rvalid, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_rdata, imem_rvalid, instr_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO of fetched instructions.
//   push/push_data : write one entry (accepted when not full, or when a pop
//                    frees a slot in the same cycle)
//   pop            : remove the head entry (ignored when empty)
//   flush          : empty the queue; wins over push and pop
//   full/empty/count : occupancy status
//   head           : current head entry, registered storage (no bypass)
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output fetch_entry_t           head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  fetch_entry_t  mem_r [DEPTH];
  logic          do_pop_s;
  logic          do_push_s;

  assign do_pop_s  = pop && (count_r != '0);
  assign do_push_s = push && ((count_r != DEPTH_C) || do_pop_s);

  assign full  = (count_r == DEPTH_C);
  assign empty = (count_r == '0);
  assign count = count_r;
  assign head  = mem_r[rd_ptr_r];

  // Storage, pointers and occupancy; flush clears pointers only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: front-end instruction fetch stage. Owns the PC, issues
// single-word reads to instruction memory, buffers returned words in
// fetch_queue and offers them to Decode over valid/ready. A taken branch
// from Execute redirects the PC to ex_pc + 4*delta, flushes the queue and
// retires in-flight reads through an epoch tag.
//   clk, rst_n    : clock, asynchronous active-low reset
//   branch_taken  : Execute reports a taken branch this cycle
//   branch_delta  : signed branch offset in instructions
//   bus (master)  : imem read port and Decode handshake
// Optional build macro FETCH_PERF_CNT_EN adds perf_fetched (transfers to
// Decode) and perf_flushed (dropped queue entries plus stale responses).
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned QUEUE_DEPTH = 2,
  parameter int unsigned IMEM_LAT    = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         branch_taken,
  input  logic [31:0]  branch_delta,
  fetch_unit_if.master bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]  perf_fetched,
  output logic [31:0]  perf_flushed
`endif
);

  localparam int unsigned CW = $clog2(QUEUE_DEPTH) + 1;
  localparam int unsigned SW = $clog2(QUEUE_DEPTH + IMEM_LAT) + 2;

  logic                run_r;
  logic [31:0]         pc_r;
  logic [31:0]         ex_pc_r;
  epoch_tag_t          epoch_r;
  logic [IMEM_LAT-1:0] pipe_vld_r;
  epoch_tag_t          pipe_tag_r [IMEM_LAT];
  logic [31:0]         pipe_pc_r  [IMEM_LAT];

  logic                q_full_s;
  logic                q_empty_s;
  logic [CW-1:0]       q_count_s;
  fetch_entry_t        q_head_s;
  fetch_entry_t        q_push_data_s;
  logic                xfer_s;
  logic                resp_s;
  logic                resp_live_s;
  logic                resp_stale_s;
  logic [SW-1:0]       inflight_s;
  logic                issue_s;

  assign xfer_s = !q_empty_s && bus.instr_ready;

  // The pipeline tail lines up with imem_rvalid because latency is fixed.
  assign resp_s       = bus.imem_rvalid && pipe_vld_r[IMEM_LAT-1];
  assign resp_live_s  = resp_s && (pipe_tag_r[IMEM_LAT-1] == epoch_r) && !branch_taken;
  assign resp_stale_s = resp_s && !resp_live_s;

  // Outstanding reads, including the one whose response returns this cycle.
  always_comb begin
    inflight_s = '0;
    for (int i = 0; i < IMEM_LAT; i++) begin
      inflight_s = inflight_s + SW'(pipe_vld_r[i]);
    end
  end

  // A Decode transfer this cycle frees its slot before any new response can
  // land, which is what sustains one instruction per cycle.
  assign issue_s = run_r && !branch_taken &&
                   ((SW'(q_count_s) + inflight_s) < (SW'(QUEUE_DEPTH) + SW'(xfer_s)));

  assign bus.imem_req  = issue_s;
  assign bus.imem_addr = pc_r;

  assign q_push_data_s = '{word: bus.imem_rdata, pc: pipe_pc_r[IMEM_LAT-1]};

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (resp_live_s),
    .push_data (q_push_data_s),
    .pop       (xfer_s),
    .flush     (branch_taken),
    .full      (q_full_s),
    .empty     (q_empty_s),
    .count     (q_count_s),
    .head      (q_head_s)
  );

  assign bus.instr_valid = !q_empty_s;
  assign bus.instr       = q_head_s.word;
  assign bus.instr_pc    = q_head_s.pc;

  // PC, epoch, Execute PC and the in-flight read pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_r      <= 1'b0;
      pc_r       <= RESET_PC;
      ex_pc_r    <= 32'h0000_0000;
      epoch_r    <= 1'b0;
      pipe_vld_r <= '0;
      for (int i = 0; i < IMEM_LAT; i++) begin
        pipe_tag_r[i] <= 1'b0;
        pipe_pc_r[i]  <= 32'h0000_0000;
      end
    end else begin
      run_r <= 1'b1;
      if (branch_taken) begin
        pc_r    <= branch_target(ex_pc_r, branch_delta);
        epoch_r <= ~epoch_r;
      end else if (issue_s) begin
        pc_r <= pc_r + 32'(INSTR_BYTES);
      end
      if (xfer_s) begin
        ex_pc_r <= q_head_s.pc;
      end
      pipe_vld_r[0] <= issue_s;
      pipe_tag_r[0] <= epoch_r;
      pipe_pc_r[0]  <= pc_r;
      for (int i = 1; i < IMEM_LAT; i++) begin
        pipe_vld_r[i] <= pipe_vld_r[i-1];
        pipe_tag_r[i] <= pipe_tag_r[i-1];
        pipe_pc_r[i]  <= pipe_pc_r[i-1];
      end
    end
  end

  // Queue-full status is implied by the issue rule; kept for visibility.
  logic unused_s;
  assign unused_s = q_full_s;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] flush_drop_s;

  // Entries lost this cycle: flushed queue contents (minus the one Decode
  // takes) plus any response that is discarded.
  always_comb begin
    flush_drop_s = 32'h0000_0000;
    if (branch_taken) begin
      flush_drop_s = 32'(q_count_s) - 32'(xfer_s);
    end else begin
      flush_drop_s = 32'h0000_0000;
    end
    flush_drop_s = flush_drop_s + 32'(resp_stale_s);
  end

  // Event counters, wrapping at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= 32'h0000_0000;
      perf_flushed <= 32'h0000_0000;
    end else begin
      perf_fetched <= perf_fetched + 32'(xfer_s);
      perf_flushed <= perf_flushed + flush_drop_s;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit. A memory model answers
// every request with addr ^ 32'hA5A5_0000 after IMEM_LAT cycles; a scoreboard
// holds the expected PC stream and is refilled on reset and on each branch.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;
  localparam int          LAT      = 1;
  localparam logic [31:0] KEY      = 32'hA5A5_0000;

  logic        clk;
  logic        rst_n;
  logic        branch_taken;
  logic [31:0] branch_delta;

  fetch_unit_if bus ();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushed;
`endif

  fetch_unit #(
    .RESET_PC    (RESET_PC),
    .QUEUE_DEPTH (DEPTH),
    .IMEM_LAT    (LAT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .branch_taken (branch_taken),
    .branch_delta (branch_delta),
    .bus          (bus)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_flushed (perf_flushed)
`endif
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          xfer_cnt = 0;
  logic [31:0] model_ex = 32'h0;
  logic [31:0] exp_q[$];
  logic [31:0] xfer_log[$];
  logic [31:0] req_log[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic push_run(input logic [31:0] start);
    for (int i = 0; i < 256; i++) begin
      exp_q.push_back(start + (32'(i) << 2));
    end
  endtask

  // Memory model: capture requests mid-cycle, answer LAT cycles later.
  initial begin : memory_model
    logic        mp_v [LAT];
    logic [31:0] mp_a [LAT];
    logic        cap_v;
    logic [31:0] cap_a;
    for (int i = 0; i < LAT; i++) begin
      mp_v[i] = 1'b0;
      mp_a[i] = 32'h0;
    end
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      cap_v = rst_n && bus.imem_req;
      cap_a = bus.imem_addr;
      if (cap_v) req_log.push_back(cap_a);
      if (!rst_n) begin
        for (int i = 0; i < LAT; i++) mp_v[i] = 1'b0;
      end
      @(posedge clk);
      #1;
      if (!rst_n) begin
        for (int i = 0; i < LAT; i++) mp_v[i] = 1'b0;
        bus.imem_rvalid = 1'b0;
      end else begin
        for (int i = LAT - 1; i > 0; i--) begin
          mp_v[i] = mp_v[i-1];
          mp_a[i] = mp_a[i-1];
        end
        mp_v[0] = cap_v;
        mp_a[0] = cap_a;
        bus.imem_rvalid = mp_v[LAT-1];
        bus.imem_rdata  = mp_a[LAT-1] ^ KEY;
      end
    end
  end

  // Scoreboard: compare every Decode transfer, refill on reset and branch.
  initial begin : monitor
    logic [31:0] old_ex;
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        push_run(RESET_PC);
        model_ex = 32'h0;
      end else begin
        old_ex = model_ex;
        if (bus.instr_valid && bus.instr_ready) begin
          check_eq("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_eq("xfer_pc", bus.instr_pc, e);
            check_eq("xfer_word", bus.instr, e ^ KEY);
            model_ex = e;
          end
          xfer_log.push_back(bus.instr_pc);
          xfer_cnt++;
        end
        if (branch_taken) begin
          exp_q.delete();
          push_run(old_ex + (branch_delta << 2));
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic run_until_ex(input logic [31:0] target, input int budget);
    bit found = 1'b0;
    bus.instr_ready = 1'b1;
    for (int i = 0; i < budget && !found; i++) begin
      if (model_ex == target) found = 1'b1;
      else cyc();
    end
    if (!found) check_eq("reach_ex_pc", model_ex, target);
  endtask

  task automatic do_branch(input logic [31:0] delta);
    bus.instr_ready = 1'b0;
    branch_taken    = 1'b1;
    branch_delta    = delta;
    xfer_log.delete();
    req_log.delete();
    cyc();
    branch_taken    = 1'b0;
    branch_delta    = 32'h0;
    bus.instr_ready = 1'b1;
  endtask

  task automatic wait_xfers(input int n, input int budget);
    for (int i = 0; i < budget && xfer_log.size() < n; i++) cyc();
    if (xfer_log.size() < n) check_eq("xfer_timeout", 32'(xfer_log.size()), 32'(n));
  endtask

  initial begin : stimulus
    int a;
    rst_n           = 1'b0;
    branch_taken    = 1'b0;
    branch_delta    = 32'h0;
    bus.instr_ready = 1'b0;
    repeat (3) cyc();
    check_eq("rst_imem_req", 32'(bus.imem_req), 32'd0);
    check_eq("rst_imem_addr", bus.imem_addr, RESET_PC);
    check_eq("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
    check_eq("rst_instr", bus.instr, 32'h0);
    check_eq("rst_instr_pc", bus.instr_pc, 32'h0);
    rst_n           = 1'b1;
    bus.instr_ready = 1'b1;

    // Streaming: one transfer per cycle once the pipe is full.
    repeat (10) cyc();
    a = xfer_cnt;
    repeat (10) cyc();
    check_eq("throughput", 32'(xfer_cnt - a), 32'd10);

    // Decode stall: head held stable, issue stops when the queue is full.
    bus.instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_eq("stall_valid", 32'(bus.instr_valid), 32'd1);
      check_eq("stall_pc", bus.instr_pc, exp_q[0]);
      check_eq("stall_word", bus.instr, exp_q[0] ^ KEY);
      if (i >= 2) check_eq("stall_no_req", 32'(bus.imem_req), 32'd0);
      cyc();
    end
    bus.instr_ready = 1'b1;
    repeat (6) cyc();

    // Reset with a full queue: outputs drop asynchronously.
    bus.instr_ready = 1'b0;
    repeat (3) cyc();
    check_eq("full_valid", 32'(bus.instr_valid), 32'd1);
    check_eq("full_no_req", 32'(bus.imem_req), 32'd0);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_valid", 32'(bus.instr_valid), 32'd0);
    check_eq("midrst_req", 32'(bus.imem_req), 32'd0);
    check_eq("midrst_addr", bus.imem_addr, RESET_PC);
    repeat (2) cyc();
`ifdef FETCH_PERF_CNT_EN
    check_eq("perf_fetched_rst", perf_fetched, 32'h0);
    check_eq("perf_flushed_rst", perf_flushed, 32'h0);
`endif
    rst_n = 1'b1;
    xfer_log.delete();
    bus.instr_ready = 1'b1;
    wait_xfers(1, 20);
    if (xfer_log.size() >= 1) check_eq("restart_pc", xfer_log[0], RESET_PC);

    // Taken branch from ex_pc 0x10, delta +3.
    run_until_ex(32'h10, 40);
    do_branch(32'd3);
    wait_xfers(1, 20);
    if (xfer_log.size() >= 1) check_eq("branch_fwd_pc", xfer_log[0], 32'h1C);

    // Branch coinciding with a response, delta -4 from 0x20.
    run_until_ex(32'h20, 40);
    check_eq("rvalid_at_branch", 32'(bus.imem_rvalid), 32'd1);
    do_branch(32'hFFFF_FFFC);
    wait_xfers(1, 20);
    if (xfer_log.size() >= 1) check_eq("branch_back_pc", xfer_log[0], 32'h10);

    // Redirect to 0xFFFF_FFF8 and fetch across the wrap.
    run_until_ex(32'h10, 40);
    do_branch(32'hFFFF_FFFA);
    wait_xfers(4, 30);
    check_eq("wrap_req_n", 32'(req_log.size() >= 3), 32'd1);
    if (req_log.size() >= 3) begin
      check_eq("wrap_req0", req_log[0], 32'hFFFF_FFF8);
      check_eq("wrap_req1", req_log[1], 32'hFFFF_FFFC);
      check_eq("wrap_req2", req_log[2], 32'h0000_0000);
    end
    if (xfer_log.size() >= 3) begin
      check_eq("wrap_xfer1", xfer_log[1], 32'hFFFF_FFFC);
      check_eq("wrap_xfer2", xfer_log[2], 32'h0000_0000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Front-end instruction fetch stage. It owns the program counter, issues single-word reads to instruction memory, and buffers returned words in a small queue.
- It hands instructions to Decode over a valid/ready handshake.
- It is the consumer of Execute's branch feedback pair (global_disable, delta_instruction). On a taken branch it redirects the PC, flushes queued and in-flight words, and restarts fetch.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be 4-byte aligned.
- QUEUE_DEPTH, 2, instruction queue entries; power of two, at least 2.
- IMEM_LAT, 1, fixed cycles from imem_req to imem_rvalid; 1 or 2.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- branch_taken  in  1  Execute global_disable; taken branch this cycle.
- branch_delta  in  32  Execute delta_instruction; signed offset in instructions, meaningful only when branch_taken=1.
- imem_req  out  1  read request strobe.
- imem_addr  out  32  word-aligned read address.
- imem_rdata  in  32  returned instruction word.
- imem_rvalid  in  1  imem_rdata valid.
- instr_valid  out  1  instr/instr_pc valid for Decode.
- instr_ready  in  1  Decode accepts the word.
- instr  out  32  instruction word.
- instr_pc  out  32  PC of instr.

Behaviour:
- Reset (async, rst_n=0):
  - PC=RESET_PC; queue empty; in-flight count=0; epoch=0.
  - Outputs: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
  - First imem_req is driven the first cycle after rst_n rises.
- Transfer to Decode: a transfer occurs when instr_valid && instr_ready. Once asserted, instr_valid holds instr and instr_pc stable until accepted or flushed.
- Issue rule: imem_req=1 iff (queue occupancy + in-flight) < QUEUE_DEPTH and branch_taken=0. On issue, PC += 4 with 32-bit wrap (32'hFFFF_FFFC → 0).
- Response handling:
  - Each request is tagged with the current epoch.
  - A response whose tag matches the current epoch is pushed into the queue together with its PC.
  - A response with a stale tag is discarded and its in-flight slot is released.
- Branch-target PC: the unit keeps an ex_pc register, loaded with instr_pc on each transfer. This is the PC of the instruction now in Execute.
- Taken branch (branch_taken=1), in the same cycle:
  - target = ex_pc + (branch_delta << 2), 32-bit wrap;
  - PC <= target; epoch toggles; queue cleared;
  - instr_valid=0 in the next cycle;
  - imem_req suppressed this cycle and resumes at target next cycle.
- Simultaneous events:
  - Branch and Decode transfer in the same cycle: the transfer still completes (ex_pc updates from it), and the flush takes priority for queue contents.
  - Branch and imem_rvalid in the same cycle: the response is discarded.
  - Queue full: no issue. Full cannot coincide with a valid response, because issue is limited by the occupancy rule.
  - Push into an empty queue: the word becomes instr_valid the next cycle (no bypass). Minimum latency from request to instr_valid is IMEM_LAT+1.
- Reset mid-operation: all in-flight responses are forgotten. The bench must not return responses after reset.
- Steady-state throughput: 1 instruction/cycle with instr_ready=1, QUEUE_DEPTH ≥ IMEM_LAT+1.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- With the macro defined:
  - Extra outputs perf_fetched[31:0] (count of transfers to Decode) and perf_flushed[31:0] (count of discarded queue entries plus stale responses).
  - Both counters reset to 0, wrap at 2^32, and are updated in the same cycle as the event.
- Without the macro: neither port nor counter exists, and behaviour is otherwise identical.

Decomposition:
- fetch_pkg holds:
  - INSTR_BYTES=4;
  - queue entry struct {logic [31:0] word; logic [31:0] pc;};
  - inflight tag typedef (epoch bit);
  - helper function computing the branch target.
- Sub-module fetch_queue: synchronous FIFO of entries.
  - Ports: push, pop, flush, full, empty, count.
  - Flush has priority over push and pop.

Test Plan:
- Reset, instr_ready=1, imem returns word = addr ^ 32'hA5A5_0000 → transfers PC 0,4,8,… with one instruction per cycle after the fill latency; instr_pc matches the address.
- instr_ready held 0 for 5 cycles → instr_valid stays 1 with instr stable; imem_req stops once occupancy reaches QUEUE_DEPTH; no word is lost or duplicated on release.
- Taken branch while ex_pc=0x10 with delta=+3 → next instruction delivered has instr_pc=0x1C; no word with pc 0x14/0x18 reaches Decode.
- Branch in the same cycle as imem_rvalid, then delta=-4 from ex_pc=0x20 → stale response dropped; fetch resumes at 0x10.
- PC 0xFFFF_FFF8, sequential fetch → next addresses 0xFFFF_FFFC, 0x0000_0000.
- rst_n pulsed low mid-stream with a full queue → instr_valid and imem_req drop immediately; fetch restarts at RESET_PC. With FETCH_PERF_CNT_EN defined, both counters read 0.
